ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb: RTL and testbench

OFS_PLAT_AVALON_MEM_RDWR_IF_TO_MEM_IF_ARB -- requirements
Module: ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb

---
 rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_pkg.sv | 13 +
 rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_if.sv | 79 +++++++
 rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb.sv | 128 ++++++++++++
 tb/tb_ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_pkg.sv
// Shared Avalon-MM types for the rd/wr to merged-bus arbiter slice.
// Widths default here; the arbiter itself takes them from its interfaces.
package ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_BURST_CNT_WIDTH = 4;

  typedef logic [1:0] avmm_resp_t;

  localparam avmm_resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_if.sv
// Split rd/wr Avalon-MM channel bundle and merged Avalon-MM bus bundle.
// to_master is the view of a block fed by a master; to_slave drives a slave.
interface ofs_plat_avalon_mem_rdwr_if
  import ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH
);
  logic [ADDR_WIDTH-1:0] rd_address;
  logic rd_read;
  logic [BURST_CNT_WIDTH-1:0] rd_burstcount;
  logic [DATA_WIDTH/8-1:0] rd_byteenable;
  logic rd_waitrequest;
  logic [DATA_WIDTH-1:0] rd_readdata;
  logic rd_readdatavalid;
  avmm_resp_t rd_response;

  logic [ADDR_WIDTH-1:0] wr_address;
  logic wr_write;
  logic [BURST_CNT_WIDTH-1:0] wr_burstcount;
  logic [DATA_WIDTH/8-1:0] wr_byteenable;
  logic [DATA_WIDTH-1:0] wr_writedata;
  logic wr_waitrequest;
  logic wr_writeresponsevalid;
  avmm_resp_t wr_response;

  modport to_master (
    input rd_address, rd_read, rd_burstcount, rd_byteenable,
    input wr_address, wr_write, wr_burstcount, wr_byteenable,
    input wr_writedata,
    output rd_waitrequest, rd_readdata, rd_readdatavalid,
    output rd_response,
    output wr_waitrequest, wr_writeresponsevalid, wr_response
  );

  modport to_slave (
    output rd_address, rd_read, rd_burstcount, rd_byteenable,
    output wr_address, wr_write, wr_burstcount, wr_byteenable,
    output wr_writedata,
    input rd_waitrequest, rd_readdata, rd_readdatavalid,
    input rd_response,
    input wr_waitrequest, wr_writeresponsevalid, wr_response
  );
endinterface

interface ofs_plat_avalon_mem_if
  import ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH
);
  logic [ADDR_WIDTH-1:0] address;
  logic read;
  logic write;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0] writedata;
  logic waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic readdatavalid;
  avmm_resp_t response;
  logic writeresponsevalid;

  modport to_slave (
    output address, read, write, burstcount, byteenable,
    output writedata,
    input waitrequest, readdata, readdatavalid, response,
    input writeresponsevalid
  );

  modport to_master (
    input address, read, write, burstcount, byteenable,
    input writedata,
    output waitrequest, readdata, readdatavalid, response,
    output writeresponsevalid
  );
endinterface

// File: rtl/ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb.sv
// Merges split rd/wr Avalon-MM channels onto one bus, alternating
// grants; write bursts own the bus until their last beat.
module ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb
  import ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  ofs_plat_avalon_mem_rdwr_if.to_master mem_master,
  ofs_plat_avalon_mem_if.to_slave mem_slave
);
  localparam int BW = mem_master.BURST_CNT_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RD_HOLD,
    WR_HOLD,
    WR_BURST
  } state_t;

  typedef logic [BW-1:0] bcnt_t;

  state_t state;
  state_t state_nxt;
  logic pri;
  logic pri_nxt;
  bcnt_t beats_left;
  bcnt_t beats_nxt;
  logic sel_rd;
  logic sel_wr;
  logic acc;

  always_comb begin
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    unique case (state)
      IDLE: begin
        sel_rd = mem_master.rd_read &&
                 (!mem_master.wr_write || !pri);
        sel_wr = mem_master.wr_write && !sel_rd;
      end
      RD_HOLD: sel_rd = 1'b1;
      WR_HOLD: sel_wr = 1'b1;
      WR_BURST: sel_wr = 1'b1;
      default: sel_rd = 1'b0;
    endcase
    // Nothing may be granted while reset is held.
    if (!reset_n) begin
      sel_rd = 1'b0;
      sel_wr = 1'b0;
    end
  end

  assign acc = !mem_slave.waitrequest;

  assign mem_slave.read = sel_rd && mem_master.rd_read;
  assign mem_slave.write = sel_wr && mem_master.wr_write;
  assign mem_slave.address = sel_wr ? mem_master.wr_address
                                    : mem_master.rd_address;
  assign mem_slave.burstcount = sel_wr ? mem_master.wr_burstcount
                                       : mem_master.rd_burstcount;
  assign mem_slave.byteenable = sel_wr ? mem_master.wr_byteenable
                                       : mem_master.rd_byteenable;
  assign mem_slave.writedata = mem_master.wr_writedata;

  assign mem_master.rd_waitrequest = mem_slave.waitrequest || !sel_rd;
  assign mem_master.wr_waitrequest = mem_slave.waitrequest || !sel_wr;

  assign mem_master.rd_readdatavalid = mem_slave.readdatavalid;
  assign mem_master.rd_readdata = mem_slave.readdata;
  assign mem_master.rd_response = mem_slave.response;
  assign mem_master.wr_writeresponsevalid = mem_slave.writeresponsevalid;
  assign mem_master.wr_response = mem_slave.response;

  always_comb begin
    state_nxt = state;
    pri_nxt = pri;
    beats_nxt = beats_left;
    unique case (state)
      WR_BURST: begin
        if (mem_slave.write && acc) begin
          beats_nxt = beats_left - bcnt_t'(1);
          if (beats_left == bcnt_t'(1)) begin
            state_nxt = IDLE;
            pri_nxt = 1'b0;
          end
        end
      end
      default: begin
        if (mem_slave.read) begin
          state_nxt = acc ? IDLE : RD_HOLD;
          if (acc) pri_nxt = 1'b1;
        end else if (mem_slave.write) begin
          if (!acc) begin
            state_nxt = WR_HOLD;
          end else if (mem_slave.burstcount == bcnt_t'(1)) begin
            state_nxt = IDLE;
            pri_nxt = 1'b0;
          end else begin
            state_nxt = WR_BURST;
            beats_nxt = mem_slave.burstcount - bcnt_t'(1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pri <= 1'b0;
      beats_left <= '0;
    end else begin
      state <= state_nxt;
      pri <= pri_nxt;
      beats_left <= beats_nxt;
    end
  end

  // A first command beat with a zero burst length is illegal.
  a_bcnt_nonzero: assert property (
    @(posedge clk) disable iff (!reset_n)
    (mem_slave.read || (mem_slave.write && state != WR_BURST))
      |-> (mem_slave.burstcount != '0)
  );

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb.sv
// Bench for the rd/wr arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  ofs_plat_avalon_mem_rdwr_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_CNT_WIDTH(4)
  ) up ();

  ofs_plat_avalon_mem_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_CNT_WIDTH(4)
  ) mem ();

  ofs_plat_avalon_mem_rdwr_if_to_mem_if_arb dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem_master(up),
    .mem_slave(mem)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    up.rd_read = 1'b0;
    up.rd_address = '0;
    up.rd_burstcount = 4'd1;
    up.rd_byteenable = '1;
    up.wr_write = 1'b0;
    up.wr_address = '0;
    up.wr_burstcount = 4'd1;
    up.wr_byteenable = '1;
    up.wr_writedata = '0;
    mem.waitrequest = 1'b0;
    mem.readdata = '0;
    mem.readdatavalid = 1'b0;
    mem.response = 2'b00;
    mem.writeresponsevalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    up.rd_read = 1'b1;
    up.wr_write = 1'b1;
    #1;
    chk("rst_read", 64'(mem.read), 64'd0);
    chk("rst_write", 64'(mem.write), 64'd0);
    chk("rst_rd_wait", 64'(up.rd_waitrequest), 64'd1);
    chk("rst_wr_wait", 64'(up.wr_waitrequest), 64'd1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic rd;
    logic wr;
    logic [3:0] bc;
    logic wt;
    logic rdv;
    logic wrv;
    logic [1:0] rsp;
    logic e_rd;
    logic e_wr;
    logic e_rdw;
    logic e_wrw;
  } vec_t;

  vec_t tv[$];

  initial begin
    bit rd_act;
    bit wr_act;
    bit wr_pend;
    int wr_beats;
    int lock;
    int rem;
    bit fav_wr;
    int g;
    bit e_read;
    bit e_write;
    bit acc;
    logic [63:0] rdat;

    idle_inputs();
    // rd, wr, bc, wt, rdv, wrv, rsp -> read, write, rd_wait, wr_wait
    tv.push_back('{0, 0, 4'd1, 0, 0, 0, 2'd0, 0, 0, 1, 1});
    tv.push_back('{1, 0, 4'd1, 0, 0, 0, 2'd1, 1, 0, 0, 1});
    tv.push_back('{1, 1, 4'd1, 0, 0, 0, 2'd0, 0, 1, 1, 0});
    tv.push_back('{1, 1, 4'd1, 0, 1, 0, 2'd0, 1, 0, 0, 1});
    tv.push_back('{1, 1, 4'd1, 1, 0, 1, 2'd3, 0, 1, 1, 1});
    tv.push_back('{1, 1, 4'd1, 1, 0, 0, 2'd0, 0, 1, 1, 1});
    tv.push_back('{1, 1, 4'd1, 0, 0, 0, 2'd0, 0, 1, 1, 0});
    tv.push_back('{0, 1, 4'd2, 0, 0, 0, 2'd0, 0, 1, 1, 0});
    tv.push_back('{1, 1, 4'd2, 0, 0, 0, 2'd0, 0, 1, 1, 0});
    tv.push_back('{1, 1, 4'd1, 0, 0, 0, 2'd0, 1, 0, 0, 1});
    tv.push_back('{0, 0, 4'd1, 0, 1, 1, 2'd2, 0, 0, 1, 1});
    tv.push_back('{0, 0, 4'd1, 1, 1, 1, 2'd0, 0, 0, 1, 1});

    do_reset();

    foreach (tv[i]) begin
      @(negedge clk);
      up.rd_read = tv[i].rd;
      up.rd_address = 32'h40;
      up.wr_write = tv[i].wr;
      up.wr_address = 32'h80;
      up.wr_burstcount = tv[i].bc;
      mem.waitrequest = tv[i].wt;
      mem.readdatavalid = tv[i].rdv;
      mem.writeresponsevalid = tv[i].wrv;
      mem.response = tv[i].rsp;
      rdat = {$urandom, $urandom};
      mem.readdata = rdat;
      #1;
      chk($sformatf("tv%0d_read", i), 64'(mem.read), 64'(tv[i].e_rd));
      chk($sformatf("tv%0d_write", i), 64'(mem.write), 64'(tv[i].e_wr));
      chk($sformatf("tv%0d_rdw", i), 64'(up.rd_waitrequest),
          64'(tv[i].e_rdw));
      chk($sformatf("tv%0d_wrw", i), 64'(up.wr_waitrequest),
          64'(tv[i].e_wrw));
      if (tv[i].e_rd)
        chk($sformatf("tv%0d_addr", i), 64'(mem.address), 64'h40);
      if (tv[i].e_wr)
        chk($sformatf("tv%0d_addr", i), 64'(mem.address), 64'h80);
      chk($sformatf("tv%0d_rdv", i), 64'(up.rd_readdatavalid),
          64'(tv[i].rdv));
      chk($sformatf("tv%0d_wrv", i), 64'(up.wr_writeresponsevalid),
          64'(tv[i].wrv));
      chk($sformatf("tv%0d_rrsp", i), 64'(up.rd_response), 64'(tv[i].rsp));
      chk($sformatf("tv%0d_wrsp", i), 64'(up.wr_response), 64'(tv[i].rsp));
      chk($sformatf("tv%0d_rdata", i), up.rd_readdata, rdat);
    end

    // Read with a 4-beat response stream.
    do_reset();
    @(negedge clk);
    up.rd_read = 1'b1;
    up.rd_address = 32'h100;
    up.rd_burstcount = 4'd4;
    #1;
    chk("rd4_read", 64'(mem.read), 64'd1);
    chk("rd4_bc", 64'(mem.burstcount), 64'd4);
    chk("rd4_addr", 64'(mem.address), 64'h100);
    @(negedge clk);
    up.rd_read = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mem.readdatavalid = 1'b1;
      mem.readdata = 64'hA000 + 64'(b);
      #1;
      chk($sformatf("rd4_rdv%0d", b), 64'(up.rd_readdatavalid), 64'd1);
      chk($sformatf("rd4_data%0d", b), up.rd_readdata, 64'hA000 + 64'(b));
    end
    @(negedge clk);
    mem.readdatavalid = 1'b0;

    // Stalled read stays put while a write arrives behind it.
    do_reset();
    @(negedge clk);
    up.rd_read = 1'b1;
    up.rd_address = 32'h40;
    up.wr_address = 32'h80;
    mem.waitrequest = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) up.wr_write = 1'b1;
      #1;
      chk($sformatf("stall%0d_read", c), 64'(mem.read), 64'd1);
      chk($sformatf("stall%0d_write", c), 64'(mem.write), 64'd0);
      chk($sformatf("stall%0d_addr", c), 64'(mem.address), 64'h40);
      @(negedge clk);
    end
    mem.waitrequest = 1'b0;
    #1;
    chk("stall_acc_read", 64'(mem.read), 64'd1);
    chk("stall_acc_rdw", 64'(up.rd_waitrequest), 64'd0);
    @(negedge clk);
    up.rd_read = 1'b0;
    #1;
    chk("stall_wr_write", 64'(mem.write), 64'd1);
    chk("stall_wr_addr", 64'(mem.address), 64'h80);
    @(negedge clk);
    idle_inputs();

    // Reset lands in the middle of a 4-beat write burst.
    do_reset();
    @(negedge clk);
    up.wr_write = 1'b1;
    up.wr_address = 32'h200;
    up.wr_burstcount = 4'd4;
    #1;
    chk("rstb_beat1", 64'(mem.write), 64'd1);
    @(negedge clk);
    #1;
    chk("rstb_beat2", 64'(mem.write), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstb_rst_write", 64'(mem.write), 64'd0);
    chk("rstb_rst_read", 64'(mem.read), 64'd0);
    chk("rstb_rst_wrw", 64'(up.wr_waitrequest), 64'd1);
    @(negedge clk);
    up.wr_write = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rstb_no_beat3", 64'(mem.write), 64'd0);
    @(negedge clk);
    up.rd_read = 1'b1;
    up.rd_address = 32'h300;
    up.rd_burstcount = 4'd1;
    up.wr_write = 1'b1;
    up.wr_address = 32'h400;
    up.wr_burstcount = 4'd1;
    #1;
    chk("rstb_pri_read", 64'(mem.read), 64'd1);
    chk("rstb_pri_write", 64'(mem.write), 64'd0);
    chk("rstb_pri_addr", 64'(mem.address), 64'h300);
    @(negedge clk);
    idle_inputs();

    // Randomized traffic against a transaction-level arbitration model.
    do_reset();
    rd_act = 0;
    wr_act = 0;
    wr_pend = 0;
    wr_beats = 0;
    lock = 0;
    rem = 0;
    fav_wr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rd_act && $urandom_range(0, 2) == 0) begin
        rd_act = 1;
        up.rd_address = $urandom;
        up.rd_burstcount = 4'($urandom_range(1, 4));
        up.rd_byteenable = 8'($urandom);
      end
      up.rd_read = rd_act;
      if (!wr_act && $urandom_range(0, 2) == 0) begin
        wr_act = 1;
        wr_beats = $urandom_range(1, 4);
        up.wr_burstcount = 4'(wr_beats);
        up.wr_address = $urandom;
        up.wr_byteenable = 8'($urandom);
      end
      up.wr_write = wr_act && (wr_pend || $urandom_range(0, 3) != 0);
      if (!wr_pend) up.wr_writedata = {$urandom, $urandom};
      mem.waitrequest = ($urandom_range(0, 3) == 0);
      mem.readdatavalid = 1'($urandom);
      mem.writeresponsevalid = 1'($urandom);
      mem.response = 2'($urandom);
      mem.readdata = {$urandom, $urandom};

      if (lock != 0) g = lock;
      else if (up.rd_read && up.wr_write) g = fav_wr ? 2 : 1;
      else if (up.rd_read) g = 1;
      else if (up.wr_write) g = 2;
      else g = 0;
      e_read = (g == 1) && up.rd_read;
      e_write = (g == 2) && up.wr_write;
      acc = !mem.waitrequest;

      #1;
      chk("rnd_read", 64'(mem.read), 64'(e_read));
      chk("rnd_write", 64'(mem.write), 64'(e_write));
      chk("rnd_rdw", 64'(up.rd_waitrequest),
          64'(mem.waitrequest || g != 1));
      chk("rnd_wrw", 64'(up.wr_waitrequest),
          64'(mem.waitrequest || g != 2));
      if (e_read) begin
        chk("rnd_raddr", 64'(mem.address), 64'(up.rd_address));
        chk("rnd_rbc", 64'(mem.burstcount), 64'(up.rd_burstcount));
        chk("rnd_rbe", 64'(mem.byteenable), 64'(up.rd_byteenable));
      end
      if (e_write) begin
        chk("rnd_waddr", 64'(mem.address), 64'(up.wr_address));
        chk("rnd_wbe", 64'(mem.byteenable), 64'(up.wr_byteenable));
      end
      chk("rnd_wdata", mem.writedata, up.wr_writedata);
      chk("rnd_rdv", 64'(up.rd_readdatavalid), 64'(mem.readdatavalid));
      chk("rnd_rdata", up.rd_readdata, mem.readdata);
      chk("rnd_wrv", 64'(up.wr_writeresponsevalid),
          64'(mem.writeresponsevalid));
      chk("rnd_rsp", 64'({up.rd_response, up.wr_response}),
          64'({mem.response, mem.response}));

      if (g == 1 && up.rd_read) begin
        if (acc) begin
          lock = 0;
          fav_wr = 1;
        end else begin
          lock = 1;
        end
      end else if (g == 2 && up.wr_write) begin
        if (rem == 0) begin
          if (!acc) lock = 2;
          else if (up.wr_burstcount == 4'd1) begin
            lock = 0;
            fav_wr = 0;
          end else begin
            lock = 2;
            rem = int'(up.wr_burstcount) - 1;
          end
        end else if (acc) begin
          rem--;
          if (rem == 0) begin
            lock = 0;
            fav_wr = 0;
          end
        end
      end

      if (e_read && acc) rd_act = 0;
      if (e_write && acc) begin
        wr_beats--;
        if (wr_beats == 0) wr_act = 0;
      end
      wr_pend = up.wr_write && !(e_write && acc);
    end

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
